// File: rtl/trade_scheduler.sv
// Round-robin front end that time-shares one day_trading engine among N_CH feed requesters.
// One transaction in flight: grant, hold the word for ENGINE_LAT cycles, capture, respond.
module trade_scheduler #(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int ENGINE_LAT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [16*N_CH-1:0]   req_data,
  output logic [N_CH-1:0]      req_ready,
  output logic [15:0]          eng_stock_out,
  input  logic [15:0]          eng_action_in,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CH_W-1:0]      resp_ch,
  output logic [15:0]          resp_action,
  output logic                 resp_err,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  localparam int unsigned      N_U      = N_CH;
  localparam int               CNT_W    = (ENGINE_LAT > 1) ? $clog2(ENGINE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENGINE_LAT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  hold_ch;
  logic [15:0]      hold_data;
  logic [CNT_W-1:0] wait_cnt;

  logic [N_CH-1:0]  grant;
  logic [CH_W-1:0]  win_ch;
  logic [CH_W-1:0]  scan_idx;
  logic [15:0]      win_data;
  logic             found;
  logic             req_hs;
  logic [CH_W-1:0]  next_ptr;

  // Scan upward from rr_ptr, wrapping modulo N_CH; the first asserted request wins.
  always_comb begin
    grant    = '0;
    win_ch   = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < N_U; k++) begin
      scan_idx = CH_W'((32'(rr_ptr) + k) % N_U);
      if (!found && req_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        win_ch          = scan_idx;
      end
    end
    win_data = 16'(req_data >> {win_ch, 4'b0000});
  end

  assign req_ready     = (state == IDLE && rst) ? grant : '0;
  assign req_hs        = |(req_valid & req_ready);
  assign next_ptr      = (hold_ch == CH_LAST) ? '0 : hold_ch + 1'b1;
  assign eng_stock_out = hold_data;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      hold_ch     <= '0;
      hold_data   <= '0;
      wait_cnt    <= '0;
      resp_valid  <= 1'b0;
      resp_ch     <= '0;
      resp_action <= '0;
      resp_err    <= 1'b0;
      done_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            hold_data <= win_data;
            hold_ch   <= win_ch;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == CNT_LAST) begin
            resp_action <= eng_action_in;
            resp_err    <= (eng_action_in == 16'd0) || (eng_action_in > 16'd8);
            resp_ch     <= hold_ch;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= next_ptr;
            done_cnt   <= done_cnt + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trade_scheduler.md
# trade_scheduler

Round-robin scheduler that shares one `day_trading` decision engine among `N_CH` stock-feed requesters. It accepts one 16-bit stock word per transaction through a valid/ready handshake. It holds that word stable on the engine input for the engine's fixed latency, then captures the engine's action code. It returns the action, tagged with the requesting channel, through a valid/ready response port. It sits between the per-ticker feed front-ends and the single engine instance.

## Interface

Parameters:
- `N_CH`, default 4: number of requesters, 2..8.
- `CH_W`, default 2: channel-ID width, equal to clog2(`N_CH`).
- `ENGINE_LAT`, default 6: cycles the engine input must be held stable before `eng_action_in` is valid, at least 1.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset. Reset is applied at the clock edge where `rst`=0.
- `req_valid`  input  N_CH  per-channel request valid.
- `req_data`  input  16*N_CH  channel i occupies bits [16i+15:16i]. Format: bit15 = ownership, [14:10] = oldest price, [9:5] = middle price, [4:0] = newest price.
- `req_ready`  output  N_CH  one-hot grant; a request is accepted when `req_valid[i]` and `req_ready[i]` are both 1 at a clock edge.
- `eng_stock_out`  output  16  drives the engine `stock_in`.
- `eng_action_in`  input  16  driven by the engine `action_out`.
- `resp_valid`  output  1  a response is pending.
- `resp_ready`  input  1  the consumer accepts the response.
- `resp_ch`  output  CH_W  channel that owns the response.
- `resp_action`  output  16  captured action code; legal codes are 1..8.
- `resp_err`  output  1  the captured code is outside 1..8.
- `busy`  output  1  the FSM is not in IDLE.
- `done_cnt`  output  16  count of completed responses.

## Operation

- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - Arbitrate round-robin among the asserted `req_valid` bits. Start the search at pointer `rr_ptr` and take the first asserted index going upward, wrapping modulo `N_CH`.
  - `req_ready` is combinational: it is the one-hot winner when the state is IDLE and any `req_valid` is set, and 0 otherwise.
  - On handshake:
    - `hold_data` <= the winner's `req_data`.
    - `hold_ch` <= the winner's index.
    - `wait_cnt` <= 0.
    - Go to WAIT.
  - No request results in staying in IDLE.
  - A requester that drops `req_valid` before it is granted loses nothing and commits nothing.
- **WAIT**
  - `eng_stock_out` = `hold_data`, stable for the whole state.
  - `wait_cnt` increments each cycle.
  - When `wait_cnt` == `ENGINE_LAT`-1, at that edge:
    - `resp_action` <= `eng_action_in`.
    - `resp_err` <= (`eng_action_in` == 0) or (`eng_action_in` > 8).
    - `resp_ch` <= `hold_ch`.
    - Go to RESP.
  - `req_ready` = 0 throughout.
- **RESP**
  - `resp_valid` = 1. `resp_action`, `resp_ch` and `resp_err` stay stable until the handshake.
  - On `resp_ready`=1 at an edge:
    - `rr_ptr` <= (`hold_ch`+1) mod `N_CH`.
    - `done_cnt` <= `done_cnt`+1, wrapping 16'hFFFF to 0.
    - Go to IDLE.
  - Back-pressure may last any number of cycles, and the engine input stays at `hold_data` during it.
- `eng_stock_out` keeps its last value in IDLE and is never driven with a partial word.
- `busy` = (state != IDLE).
- The scheduler holds only one transaction at a time. It does not accept a new request in the same cycle as a response handshake.

## Timing

- **Reset values** (`rst`=0 at an edge):
  - State = IDLE, `rr_ptr` = 0.
  - `eng_stock_out` = 0, `hold_data` = 0, `hold_ch` = 0.
  - `resp_valid` = 0, `resp_action` = 0, `resp_ch` = 0, `resp_err` = 0.
  - `done_cnt` = 0, `wait_cnt` = 0.
  - `req_ready` is 0 during the reset cycle.
- **Reset mid-operation** (WAIT or RESP): the in-flight transaction is dropped with no response, `done_cnt` is cleared, and arbitration restarts at channel 0.
- **Latency:**
  - Handshake at edge T.
  - `eng_stock_out` is valid after T.
  - The action is captured and `resp_valid` rises at edge T+`ENGINE_LAT`.
  - With `resp_ready` held at 1, the response handshake happens at T+`ENGINE_LAT`+1 and IDLE is reached after it.
  - The next grant can occur at T+`ENGINE_LAT`+2.
  - Peak throughput is one decision per `ENGINE_LAT`+2 cycles.
- **Simultaneous requests:** exactly one grant per transaction. A channel that stays asserted is served within `N_CH` transactions.
- **`rr_ptr` wrap:** after channel `N_CH`-1 is served, the pointer returns to 0.
- **Requester rule:** `req_data[i]` must be stable while `req_valid[i]`=1 and ungranted. The scheduler samples it only at the handshake edge.

## Test plan

- **Reset and idle.** Hold `rst`=0 for 2 cycles, then release with no requests. Required: all outputs at their reset values, `busy`=0, `req_ready`=0.
- **Single request.** Raise `req_valid[0]` with data 16'h294A (not owned; prices 10, 10, 10) against the real engine, with `resp_ready`=1. Required:
  - `req_ready[0]`=1 in the same cycle.
  - `resp_valid` rises exactly 6 cycles after the handshake, with `resp_ch`=0, `resp_action`=7, `resp_err`=0.
  - `done_cnt`=1 afterwards.
- **Round-robin fairness.** Hold all four `req_valid` bits high; channel 2 carries 16'h954F (owned; prices 5, 10, 15). Required: grant order 0, 1, 2, 3, 0; channel 2's response has `resp_action`=1.
- **Back-pressure.** Hold `resp_ready`=0 for 10 cycles after `resp_valid` rises. Required:
  - `resp_*` and `eng_stock_out` stay stable.
  - `req_ready` stays 0.
  - `done_cnt` increments only on the `resp_ready` edge.
- **Illegal code.** A stub engine returns 0 and then 9. Required: `resp_err`=1 for both responses; a stub return of 8 gives `resp_err`=0.
- **Reset mid-WAIT.** Apply `rst`=0 three cycles after a grant to channel 3. Required:
  - No response is produced.
  - `done_cnt`=0 and `rr_ptr`=0.
  - With channels 0 and 3 both pending afterwards, the next grant goes to channel 0.
